// File: rtl/rubiks_polibot_sequenciador_movimento.sv
// Move sequencer: expands a 4-bit move code into timed base/arm servo steps.
// Rejects moves that would push the base outside its 0..180 degree travel.
module rubiks_polibot_sequenciador_movimento #(
    parameter int TEMPO_PASSO = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       aciona_movimento,
    input  logic [3:0] codigo_movimento,
    output logic [1:0] pos_base,
    output logic [1:0] pos_braco,
    output logic       fim_movimento,
    output logic       erro_movimento,
    output logic       ocupado,
    output logic [3:0] db_estado,
    output logic [1:0] db_passo
);

    localparam int CW = $clog2(TEMPO_PASSO + 1);

    localparam logic [1:0] ALTO    = 2'd0;
    localparam logic [1:0] TRAVA   = 2'd1;
    localparam logic [1:0] EMPURRA = 2'd2;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        DECODIFICA = 3'd1,
        APLICA     = 3'd2,
        ESPERA     = 3'd3,
        PROXIMO    = 3'd4,
        CONCLUIDO  = 3'd5
    } estado_t;

    estado_t       estado;
    logic [3:0]    codigo;
    logic [1:0]    passo;
    logic [CW-1:0] cnt;
    logic          erro;

    logic          invalido;
    logic [1:0]    n_total;
    logic          passo_base;
    logic [1:0]    alvo_base;
    logic [1:0]    alvo_braco;

    always_comb begin
        invalido = 1'b0;
        n_total  = 2'd0;
        case (codigo)
            4'h0: n_total = 2'd0;
            4'h1: begin n_total = 2'd2; invalido = (pos_base == 2'd2); end
            4'h2: begin n_total = 2'd2; invalido = (pos_base == 2'd0); end
            4'h3: n_total = 2'd2;
            4'h4: begin n_total = 2'd3; invalido = (pos_base == 2'd2); end
            4'h5: begin n_total = 2'd3; invalido = (pos_base == 2'd0); end
            4'h6: begin n_total = 2'd3; invalido = pos_base[0]; end
            4'h7: n_total = 2'd2;
            default: invalido = 1'b1;
        endcase
    end

    // Base target is taken from the live base register at APLICA time.
    always_comb begin
        alvo_base = pos_base;
        case (codigo)
            4'h1, 4'h4: alvo_base = pos_base + 2'd1;
            4'h2, 4'h5: alvo_base = pos_base - 2'd1;
            4'h6:       alvo_base = (pos_base == 2'd0) ? 2'd2 : 2'd0;
            4'h7:       alvo_base = 2'd1;
            default:    alvo_base = pos_base;
        endcase
    end

    always_comb begin
        passo_base = 1'b0;
        alvo_braco = ALTO;
        case (codigo)
            4'h1, 4'h2, 4'h7: passo_base = (passo == 2'd1);
            4'h3: alvo_braco = (passo == 2'd0) ? EMPURRA : ALTO;
            4'h4, 4'h5, 4'h6: begin
                passo_base = (passo == 2'd1);
                alvo_braco = (passo == 2'd0) ? TRAVA : ALTO;
            end
            default: passo_base = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= OCIOSO;
            codigo    <= 4'h0;
            passo     <= 2'd0;
            cnt       <= '0;
            erro      <= 1'b0;
            pos_base  <= 2'd1;
            pos_braco <= ALTO;
        end else begin
            case (estado)
                OCIOSO: if (aciona_movimento) begin
                    codigo <= codigo_movimento;
                    estado <= DECODIFICA;
                end
                DECODIFICA: begin
                    erro  <= invalido;
                    passo <= 2'd0;
                    if (invalido || n_total == 2'd0) estado <= CONCLUIDO;
                    else                             estado <= APLICA;
                end
                APLICA: begin
                    if (passo_base) pos_base  <= alvo_base;
                    else            pos_braco <= alvo_braco;
                    cnt    <= '0;
                    estado <= ESPERA;
                end
                ESPERA: begin
                    if (cnt == CW'(TEMPO_PASSO - 1)) estado <= PROXIMO;
                    else                             cnt <= cnt + 1'b1;
                end
                PROXIMO: begin
                    if (passo == n_total - 2'd1) begin
                        estado <= CONCLUIDO;
                    end else begin
                        passo  <= passo + 2'd1;
                        estado <= APLICA;
                    end
                end
                CONCLUIDO: if (!aciona_movimento) estado <= OCIOSO;
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign fim_movimento  = (estado == CONCLUIDO);
    assign erro_movimento = (estado == CONCLUIDO) && erro;
    assign ocupado        = (estado != OCIOSO);
    assign db_estado      = {1'b0, estado};
    assign db_passo       = passo;

endmodule

// File: tb/tb_rubiks_polibot_sequenciador_movimento.sv
// Directed bench for the move sequencer with TEMPO_PASSO=4 (6 cycles/step).
// Cycle rel=1 is the cycle right after the acceptance edge.
module tb_rubiks_polibot_sequenciador_movimento;

    logic       clock = 1'b0;
    logic       reset;
    logic       aciona_movimento;
    logic [3:0] codigo_movimento;
    logic [1:0] pos_base;
    logic [1:0] pos_braco;
    logic       fim_movimento;
    logic       erro_movimento;
    logic       ocupado;
    logic [3:0] db_estado;
    logic [1:0] db_passo;

    int n_cmp = 0;
    int n_err = 0;
    int rel   = 0;

    rubiks_polibot_sequenciador_movimento #(.TEMPO_PASSO(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .aciona_movimento (aciona_movimento),
        .codigo_movimento (codigo_movimento),
        .pos_base         (pos_base),
        .pos_braco        (pos_braco),
        .fim_movimento    (fim_movimento),
        .erro_movimento   (erro_movimento),
        .ocupado          (ocupado),
        .db_estado        (db_estado),
        .db_passo         (db_passo)
    );

    always #5 clock = ~clock;

    task automatic accept(input logic [3:0] code);
        @(negedge clock);
        codigo_movimento = code;
        aciona_movimento = 1'b1;
        @(posedge clock);
        rel = 0;
    endtask

    task automatic to_cycle(input int c);
        while (rel < c) begin
            @(negedge clock);
            rel++;
        end
    endtask

    task automatic release_req();
        aciona_movimento = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (db_estado !== 4'd0) begin
            n_err++;
            $display("FAIL release_idle: estado=%0d want 0", db_estado);
        end
    endtask

    task automatic do_move(input logic [3:0] code, input int lat,
                           input logic e, input logic [1:0] b,
                           input logic [1:0] a);
        accept(code);
        to_cycle(1);
        n_cmp++;
        if (ocupado !== 1'b1 || fim_movimento !== 1'b0) begin
            n_err++;
            $display("FAIL busy_%h: ocupado=%b fim=%b want 1 0",
                     code, ocupado, fim_movimento);
        end
        while (!fim_movimento && rel < 100) to_cycle(rel + 1);
        n_cmp++;
        if (rel !== lat) begin
            n_err++;
            $display("FAIL latency_%h: got %0d want %0d", code, rel, lat);
        end
        n_cmp++;
        if (erro_movimento !== e || pos_base !== b || pos_braco !== a) begin
            n_err++;
            $display("FAIL result_%h: erro=%b base=%b braco=%b want %b %b %b",
                     code, erro_movimento, pos_base, pos_braco, e, b, a);
        end
        release_req();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        aciona_movimento = 1'b0;
        codigo_movimento = 4'h0;
        #12;
        n_cmp++;
        if (pos_base !== 2'b01 || pos_braco !== 2'b00 ||
            fim_movimento !== 1'b0 || erro_movimento !== 1'b0 ||
            ocupado !== 1'b0 || db_estado !== 4'd0 || db_passo !== 2'd0) begin
            n_err++;
            $display("FAIL reset_vals: base=%b braco=%b fim=%b ocup=%b st=%0d",
                     pos_base, pos_braco, fim_movimento, ocupado, db_estado);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_camada_h();
        accept(4'h4);
        to_cycle(2);
        n_cmp++;
        if (pos_braco !== 2'b00 || pos_base !== 2'b01 || db_estado !== 4'd2) begin
            n_err++;
            $display("FAIL c4_pre: braco=%b base=%b st=%0d", pos_braco,
                     pos_base, db_estado);
        end
        to_cycle(3);
        n_cmp++;
        if (pos_braco !== 2'b01 || pos_base !== 2'b01) begin
            n_err++;
            $display("FAIL c4_step0: braco=%b base=%b want 01 01",
                     pos_braco, pos_base);
        end
        to_cycle(8);
        n_cmp++;
        if (pos_base !== 2'b01 || db_passo !== 2'd1) begin
            n_err++;
            $display("FAIL c4_hold: base=%b passo=%0d want 01 1",
                     pos_base, db_passo);
        end
        to_cycle(9);
        n_cmp++;
        if (pos_base !== 2'b10 || pos_braco !== 2'b01) begin
            n_err++;
            $display("FAIL c4_step1: base=%b braco=%b want 10 01",
                     pos_base, pos_braco);
        end
        to_cycle(14);
        n_cmp++;
        if (pos_braco !== 2'b01) begin
            n_err++;
            $display("FAIL c4_hold2: braco=%b want 01", pos_braco);
        end
        to_cycle(15);
        n_cmp++;
        if (pos_braco !== 2'b00) begin
            n_err++;
            $display("FAIL c4_step2: braco=%b want 00", pos_braco);
        end
        to_cycle(19);
        n_cmp++;
        if (fim_movimento !== 1'b0) begin
            n_err++;
            $display("FAIL c4_early: fim=%b at 19", fim_movimento);
        end
        to_cycle(20);
        n_cmp++;
        if (fim_movimento !== 1'b1 || erro_movimento !== 1'b0) begin
            n_err++;
            $display("FAIL c4_done: fim=%b erro=%b want 1 0",
                     fim_movimento, erro_movimento);
        end
        release_req();
    endtask

    task automatic test_invalid();
        do_move(4'h1, 2, 1'b1, 2'b10, 2'b00);
        do_move(4'h9, 2, 1'b1, 2'b10, 2'b00);
        do_move(4'hF, 2, 1'b1, 2'b10, 2'b00);
    endtask

    task automatic test_camada_180();
        do_move(4'h6, 20, 1'b0, 2'b00, 2'b00);
        do_move(4'h2, 2, 1'b1, 2'b00, 2'b00);
        do_move(4'h6, 20, 1'b0, 2'b10, 2'b00);
        do_move(4'h7, 14, 1'b0, 2'b01, 2'b00);
        do_move(4'h6, 2, 1'b1, 2'b01, 2'b00);
    endtask

    task automatic test_back_to_back();
        accept(4'h0);
        to_cycle(2);
        n_cmp++;
        if (fim_movimento !== 1'b1 || erro_movimento !== 1'b0) begin
            n_err++;
            $display("FAIL nop_done: fim=%b erro=%b", fim_movimento,
                     erro_movimento);
        end
        to_cycle(7);
        n_cmp++;
        if (fim_movimento !== 1'b1 || db_estado !== 4'd5) begin
            n_err++;
            $display("FAIL nop_hold: fim=%b st=%0d want 1 5",
                     fim_movimento, db_estado);
        end
        aciona_movimento = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL nop_idle: st=%0d ocup=%b", db_estado, ocupado);
        end
        codigo_movimento = 4'h0;
        aciona_movimento = 1'b1;
        @(posedge clock);
        rel = 0;
        to_cycle(1);
        n_cmp++;
        if (db_estado !== 4'd1 || ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL reaccept: st=%0d ocup=%b want 1 1",
                     db_estado, ocupado);
        end
        to_cycle(2);
        n_cmp++;
        if (fim_movimento !== 1'b1) begin
            n_err++;
            $display("FAIL reaccept_done: fim=%b want 1", fim_movimento);
        end
        release_req();
    endtask

    task automatic test_reset_mid_move();
        int seen;
        accept(4'h3);
        to_cycle(4);
        n_cmp++;
        if (pos_braco !== 2'b10 || db_estado !== 4'd3) begin
            n_err++;
            $display("FAIL tomba_push: braco=%b st=%0d want 10 3",
                     pos_braco, db_estado);
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pos_braco !== 2'b00 || pos_base !== 2'b01 ||
            fim_movimento !== 1'b0 || ocupado !== 1'b0 ||
            db_estado !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset: braco=%b base=%b fim=%b ocup=%b st=%0d",
                     pos_braco, pos_base, fim_movimento, ocupado, db_estado);
        end
        aciona_movimento = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (fim_movimento) seen++;
        end
        n_cmp++;
        if (seen !== 0 || db_estado !== 4'd0) begin
            n_err++;
            $display("FAIL no_fim_after_reset: fim cycles=%0d st=%0d",
                     seen, db_estado);
        end
    endtask

    initial begin
        test_reset();
        test_camada_h();
        test_invalid();
        test_camada_180();
        test_back_to_back();
        test_reset_mid_move();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rubiks_polibot_sequenciador_movimento.md
# rubiks_polibot_sequenciador_movimento

Sequencer that turns one 4-bit move code from the main control unit into a timed series of servo steps for the base servo and the arm servo. It sits between the main control unit (`aciona_movimento` / `fim_movimento` handshake) and the PWM servo drivers, which consume its position-code outputs. It rejects moves that would drive the base beyond its 0°–180° travel.

## Interface
- `TEMPO_PASSO`, default 25_000_000: settle time in clock cycles per servo step (0.5 s at 50 MHz). Must be ≥1. Benches use 4.
- `clock  in  1`: system clock.
- `reset  in  1`: asynchronous, active-high.
- `aciona_movimento  in  1`: level request from the main control unit, held until `fim_movimento`.
- `codigo_movimento  in  4`: move code, sampled only on acceptance.
- `pos_base  out  2`: base position, 00=0°, 01=90°, 10=180°. 11 is never driven.
- `pos_braco  out  2`: arm position, 00=ALTO, 01=TRAVA, 10=EMPURRA. 11 is never driven.
- `fim_movimento  out  1`: move finished (state CONCLUIDO).
- `erro_movimento  out  1`: finished move was rejected. Valid only while `fim_movimento`=1.
- `ocupado  out  1`: 1 in every state except OCIOSO.
- `db_estado  out  4`: state code.
- `db_passo  out  2`: current step index.

## Operation
- Move codes and their step lists (b = current base position):
  - 0x0 NOP: no steps.
  - 0x1 GIRA_H: braco=ALTO; base=b+1.
  - 0x2 GIRA_AH: braco=ALTO; base=b−1.
  - 0x3 TOMBA: braco=EMPURRA; braco=ALTO.
  - 0x4 CAMADA_H: braco=TRAVA; base=b+1; braco=ALTO.
  - 0x5 CAMADA_AH: braco=TRAVA; base=b−1; braco=ALTO.
  - 0x6 CAMADA_180: braco=TRAVA; base=b+2 if b=0, b−2 if b=2; braco=ALTO.
  - 0x7 POSICAO_INICIAL: braco=ALTO; base=01.
- Invalid moves: codes 0x8–0xF; +1 with b=2; −1 with b=0; 0x6 with b=1. An invalid move runs no steps, leaves the outputs unchanged and finishes with `erro_movimento`=1.
- Every listed step executes and waits the full settle time, even when its target equals the current position.
- States and transitions (db_estado in brackets):
  - OCIOSO [0]: when `aciona_movimento`=1, latch `codigo_movimento`, go to DECODIFICA.
  - DECODIFICA [1]: validate the move and set the step count N. If invalid or N=0, go to CONCLUIDO; else go to APLICA with step index 0.
  - APLICA [2]: register the step's target into `pos_base` or `pos_braco`, clear the wait counter, go to ESPERA.
  - ESPERA [3]: count TEMPO_PASSO cycles, then go to PROXIMO.
  - PROXIMO [4]: if this was the last step, go to CONCLUIDO; else increment the step index and go to APLICA.
  - CONCLUIDO [5]: `fim_movimento`=1 and `erro_movimento`=error flag. Go to OCIOSO when `aciona_movimento`=0.
  - Unused state codes go to OCIOSO.
- `aciona_movimento` falling mid-move is ignored; the move completes.
- A new move needs `aciona_movimento` low for at least one cycle after CONCLUIDO, because acceptance happens only in OCIOSO.
- Wait counter width is clog2(TEMPO_PASSO+1). No wrap occurs.
- Reset values: `pos_base`=01, `pos_braco`=00, all flags 0, state OCIOSO, `db_passo`=00. Reset mid-move aborts immediately to these values.

## Timing
- Acceptance edge k is the rising edge at which OCIOSO samples `aciona_movimento`=1. `ocupado`=1 from cycle k+1.
- For N steps, `fim_movimento` first goes high in cycle k+2+N·(TEMPO_PASSO+2). N=0 or invalid gives k+2.
- Each servo output changes at the edge ending APLICA. It stays stable for TEMPO_PASSO+2 cycles before the next step.
- `fim_movimento` stays high while `aciona_movimento`=1. If `aciona_movimento` is already low in the first CONCLUIDO cycle, `fim_movimento` is a single-cycle pulse.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use TEMPO_PASSO=4, so each step takes 6 cycles.
- Reset pulse mid-run → `pos_base`=01, `pos_braco`=00, `fim_movimento`=0, `ocupado`=0, `db_estado`=0 asynchronously.
- b=01, code 0x4 → `pos_braco` 01, then `pos_base` 10, then `pos_braco` 00, each 6 cycles apart; `fim_movimento`=1 at k+20; `erro_movimento`=0.
- b=10, code 0x1 → `fim_movimento`=1 and `erro_movimento`=1 at k+2; outputs unchanged. Codes 0x9 and 0xF give the same response.
- Code 0x6 from b=10 → base ends at 00. Repeat → base ends at 10. Code 0x6 from b=01 → error.
- Code 0x0 with `aciona_movimento` held 5 cycles past `fim_movimento` → `fim_movimento` high at k+2 and held; OCIOSO one cycle after the drop; immediate re-assert of `aciona_movimento` is accepted.
- Code 0x3, reset asserted during the first ESPERA → `pos_braco` returns to 00 at once; no `fim_movimento` is issued.
